calc_key_entry: RTL and testbench
=================================

// Module: calc_key_entry
// PURPOSE
//   Operand-entry front end of the integer calculator. Debounces the ten digit
//   pushbuttons (swp0..swp9) and eight operation switches (swd1..swd8) and
//   edge-detects each press. Accumulates decimal digits into a binary operand.
//   Hands each {operand, op} token to the calculator core over a valid/ready
//   handshake; also exposes the live entry value for the seg/LCD display path.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive stable-high cycles before a press counts (>=1)
//   MAX_DIGITS       4   max decimal digits per operand
//   WIDTH            16  operand width, unsigned; must hold 10^MAX_DIGITS-1
// PORTS
//   clk            in   1      system clock
//   rst            in   1      async reset, active-low
//   digit_btn      in   10     raw digit buttons, bit i = digit i (swp0..swp9)
//   op_btn         in   8      raw op switches, bit j = swd(j+1); bit1 = sum
//   out_valid      out  1      token available
//   out_ready      in   1      core accepts token
//   out_operand    out  WIDTH  entered operand, binary
//   out_op         out  3      index j of the op switch that closed the operand
//   entry_value    out  WIDTH  running accumulator, for display
//   digit_count    out  3      digits entered so far, 0..MAX_DIGITS
//   digit_ovf      out  1      sticky: a digit was dropped at MAX_DIGITS
// BEHAVIOUR
//   Reset (rst=0, async): all outputs 0, all debounce counters/synchronisers 0,
//     FSM -> IDLE. Reset mid-handshake drops the pending token.
//   Input path: 2-flop synchroniser per button, then per-button counter; clean
//     level rises after DEBOUNCE_CYCLES consecutive high samples, falls on first
//     low sample. One-cycle press pulse on each clean rising edge. A held button
//     yields exactly one press.
//   Priority: several digit pulses in one cycle -> lowest index only. Several
//     op pulses in one cycle -> lowest index only. Digit and op pulses in the
//     same cycle -> op wins; that digit is dropped (not counted as ovf).
//   FSM states: IDLE (acc=0,count=0), ENTRY, HOLD.
//     IDLE/ENTRY + digit d: if count<MAX_DIGITS: acc<=acc*10+d, count++, ->ENTRY;
//       else acc unchanged, digit_ovf<=1.
//     IDLE/ENTRY + op j: out_operand<=acc (0 from IDLE), out_op<=j,
//       out_valid<=1, acc<=0, count<=0, digit_ovf<=0, ->HOLD.
//     HOLD: out_operand/out_op held stable; digit and op presses ignored.
//       out_valid&&out_ready -> out_valid<=0, ->IDLE next cycle.
//   Latency: accumulator updated 1 cycle after press pulse; out_valid rises
//     1 cycle after op pulse. Press pulse lags raw edge by 2+DEBOUNCE_CYCLES.
//   Arithmetic: acc*10+d computed at WIDTH+4 bits, truncated to WIDTH; never
//     overflows under the WIDTH constraint. Leading zeros count as digits.
//   entry_value = acc; digit_count = count (registered).
// CONFIGURATION
//   KEY_ECHO_EN defined: adds outputs key_stb (1 cycle per accepted press,
//     digit or op, after priority resolution) and key_code[4:0] (0..9 digit,
//     16+j op j), both reset 0; feeds the LCD character writer.
//   Undefined: ports absent; all other behaviour identical.
// TESTING
//   (DEBOUNCE_CYCLES=4, MAX_DIGITS=4, WIDTH=16, out_ready=1 unless noted)
//   1. Press 2,3 then op1 -> one token {23,1}; entry_value 2,23,0; count 1,2,0.
//   2. 4,5,6 op1 then 2,3,4 op7 -> tokens {456,1},{234,7} in order.
//   3. 1,2,3,4,5 -> entry_value=1234, digit_ovf=1; op1 -> {1234,1}, ovf=0.
//   4. out_ready=0: 7 op1 -> out_valid held with {7,1}; press 9 ignored;
//      ready=1 -> one accept, entry_value stays 0, back in IDLE.
//   5. Glitch: digit 5 high 3 cycles -> no press; held 50 cycles -> one press.
//   6. Digits 3,8 together -> acc=3; digit 4 + op2 together -> {3,2}, digit dropped;
//      rst low mid-HOLD -> out_valid=0 immediately, all outputs 0.

Source files
------------

// File: rtl/calc_key_entry_if.sv
// ----------------------------------------------------------------------------
// calc_key_entry_if
//   Token handshake between the operand-entry front end and the calculator
//   core. One token is {operand, op}, moved with a valid/ready handshake.
//
//   Signals
//     out_valid    producer -> consumer   token available
//     out_ready    consumer -> producer   consumer accepts token this cycle
//     out_operand  producer -> consumer   operand, unsigned binary, WIDTH bits
//     out_op       producer -> consumer   index of the op switch that closed it
//
//   Modports
//     master : token producer (calc_key_entry)
//     slave  : token consumer (calculator core)
// ----------------------------------------------------------------------------
interface calc_key_entry_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_operand;
    logic [2:0]       out_op;

    modport master (
        output out_valid,
        output out_operand,
        output out_op,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_operand,
        input  out_op,
        output out_ready
    );
endinterface

// File: rtl/calc_key_entry.sv
// ----------------------------------------------------------------------------
// calc_key_entry
//   Operand-entry front end of the integer calculator. Synchronises and
//   debounces ten digit buttons and eight op switches, turns each clean press
//   into a one-cycle pulse, accumulates decimal digits into a binary operand
//   and hands {operand, op} tokens to the core over a valid/ready handshake.
//
//   Parameters
//     DEBOUNCE_CYCLES  consecutive stable-high samples before a press counts
//     MAX_DIGITS       maximum decimal digits per operand (<= 7)
//     WIDTH            operand width; must hold 10^MAX_DIGITS-1
//
//   Ports
//     i_clk            system clock
//     i_rst_n          asynchronous reset, active-low
//     i_digit_btn[9:0] raw digit buttons, bit i = digit i
//     i_op_btn[7:0]    raw op switches, bit j = op j
//     o_tok            token handshake (master side of calc_key_entry_if)
//     o_entry_value    running accumulator for the display path
//     o_digit_count    digits entered so far, 0..MAX_DIGITS
//     o_digit_ovf      sticky: a digit was dropped because MAX_DIGITS was hit
//
//   Optional feature (macro KEY_ECHO_EN)
//     o_key_stb        one-cycle strobe per accepted press (digit or op)
//     o_key_code[4:0]  0..9 for a digit, 16+j for op j
// ----------------------------------------------------------------------------
module calc_key_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 4,
    parameter int WIDTH           = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [9:0]            i_digit_btn,
    input  logic [7:0]            i_op_btn,
    calc_key_entry_if.master      o_tok,
    output logic [WIDTH-1:0]      o_entry_value,
    output logic [2:0]            o_digit_count,
    output logic                  o_digit_ovf
`ifdef KEY_ECHO_EN
    ,
    output logic                  o_key_stb,
    output logic [4:0]            o_key_code
`endif
);

    localparam int NBTN = 18;
    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, then per-button debounce counter.
    // Digits occupy bits 0..9, ops bits 10..17.
    // ------------------------------------------------------------------
    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] w_pulse;

    assign w_raw = {i_op_btn, i_digit_btn};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_deb
            logic [CW-1:0] r_cnt;
            logic          r_clean;
            logic          r_pulse;
            logic          w_clean_next;

            // The counter saturates at DEBOUNCE_CYCLES-1; the next high sample
            // after that is the DEBOUNCE_CYCLES-th one, so the clean level
            // rises on it. Any low sample clears everything at once.
            assign w_clean_next = r_sync2[gi] &&
                                  (r_clean || (r_cnt == CW'(DEBOUNCE_CYCLES - 1)));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                    r_pulse <= 1'b0;
                end else begin
                    if (!r_sync2[gi]) begin
                        r_cnt <= '0;
                    end else if (r_cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    r_clean <= w_clean_next;
                    r_pulse <= w_clean_next && !r_clean;
                end
            end

            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority: lowest-index digit, lowest-index op; an op beats a digit.
    // ------------------------------------------------------------------
    logic       w_dig_hit;
    logic       w_op_hit;
    logic [3:0] w_dig;
    logic [2:0] w_op;

    always_comb begin
        w_dig = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_pulse[i]) w_dig = 4'(i);
        end
        w_op = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (w_pulse[10 + j]) w_op = 3'(j);
        end
    end

    assign w_dig_hit = |w_pulse[9:0];
    assign w_op_hit  = |w_pulse[17:10];

    // ------------------------------------------------------------------
    // Accumulator step. acc*10+d truncated to WIDTH equals the same sum
    // evaluated modulo 2^WIDTH, so the shift-add form stays at WIDTH bits.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + WIDTH'(w_dig);

    // ------------------------------------------------------------------
    // Entry FSM with registered outputs.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_count;
    logic             r_ovf;
    logic             r_valid;
    logic [WIDTH-1:0] r_operand;
    logic [2:0]       r_op;
`ifdef KEY_ECHO_EN
    logic             r_key_stb;
    logic [4:0]       r_key_code;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_operand <= '0;
            r_op      <= '0;
`ifdef KEY_ECHO_EN
            r_key_stb  <= 1'b0;
            r_key_code <= '0;
`endif
        end else begin
`ifdef KEY_ECHO_EN
            r_key_stb <= 1'b0;
`endif
            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    if (w_op_hit) begin
                        // IDLE always holds acc=0, so this also covers the
                        // "operand 0 from IDLE" case.
                        r_operand <= r_acc;
                        r_op      <= w_op;
                        r_valid   <= 1'b1;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                        r_state   <= ST_HOLD;
`ifdef KEY_ECHO_EN
                        r_key_stb  <= 1'b1;
                        r_key_code <= {2'b10, w_op};
`endif
                    end else if (w_dig_hit) begin
                        if (r_count < 3'(MAX_DIGITS)) begin
                            r_acc   <= w_acc_next;
                            r_count <= r_count + 3'd1;
                            r_state <= ST_ENTRY;
`ifdef KEY_ECHO_EN
                            r_key_stb  <= 1'b1;
                            r_key_code <= {1'b0, w_dig};
`endif
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Token held stable; presses ignored until accepted.
                    if (r_valid && o_tok.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tok.out_valid   = r_valid;
    assign o_tok.out_operand = r_operand;
    assign o_tok.out_op      = r_op;
    assign o_entry_value     = r_acc;
    assign o_digit_count     = r_count;
    assign o_digit_ovf       = r_ovf;
`ifdef KEY_ECHO_EN
    assign o_key_stb         = r_key_stb;
    assign o_key_code        = r_key_code;
`endif

endmodule

// File: tb/tb_calc_key_entry.sv
// ----------------------------------------------------------------------------
// tb_calc_key_entry
//   Directed scenarios plus randomised digit/op sequences for calc_key_entry.
//   Expected values come from an integer model of the entry rules (decimal
//   accumulation, digit limit, priority, hold behaviour) and a token queue.
// ----------------------------------------------------------------------------
module tb_calc_key_entry;

    localparam int WIDTH = 16;
    localparam int MAXD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  dbtn = '0;
    logic [7:0]  obtn = '0;
    logic [WIDTH-1:0] entry_value;
    logic [2:0]  digit_count;
    logic        digit_ovf;

    calc_key_entry_if #(.WIDTH(WIDTH)) tok ();

    calc_key_entry #(
        .DEBOUNCE_CYCLES(4),
        .MAX_DIGITS(MAXD),
        .WIDTH(WIDTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_digit_btn   (dbtn),
        .i_op_btn      (obtn),
        .o_tok         (tok),
        .o_entry_value (entry_value),
        .o_digit_count (digit_count),
        .o_digit_ovf   (digit_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int val;
        int op;
    } tok_t;

    tok_t exp_q[$];
    tok_t got_q[$];

    // Reference model state
    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_hold = 1'b0;

    // Collect accepted tokens: valid&&ready at the negedge means the
    // handshake completes on the next rising edge.
    always @(negedge clk) begin
        tok_t t;
        if (rst_n && tok.out_valid && tok.out_ready) begin
            t.val = int'(tok.out_operand);
            t.op  = int'(tok.out_op);
            got_q.push_back(t);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input int mask);
        for (int i = 0; i < 32; i++) begin
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_press(input int dm, input int om);
        tok_t t;
        if (m_hold) return;
        if (om != 0) begin
            t.val = m_acc;
            t.op  = lowest(om);
            exp_q.push_back(t);
            m_acc  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_hold = !tok.out_ready;
        end else if (dm != 0) begin
            if (m_cnt < MAXD) begin
                m_acc = m_acc * 10 + lowest(dm);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".entry"}, int'(entry_value), m_acc);
        check({tag, ".count"}, int'(digit_count), m_cnt);
        check({tag, ".ovf"},   int'(digit_ovf),   int'(m_ovf));
        $display("step %s: entry=%0d count=%0d ovf=%0d valid=%0d",
                 tag, entry_value, digit_count, digit_ovf, tok.out_valid);
    endtask

    // Drive a press pattern for 'hold' cycles, release, let it settle.
    task automatic press(input string tag, input logic [9:0] dm,
                         input logic [7:0] om, input int hold);
        dbtn = dm;
        obtn = om;
        cyc(hold);
        dbtn = '0;
        obtn = '0;
        cyc(8);
        model_press(int'(dm), int'(om));
        check_state(tag);
    endtask

    task automatic check_tokens(input string tag);
        tok_t e, g;
        check({tag, ".ntok"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, ".operand"}, g.val, e.val);
            check({tag, ".op"},      g.op,  e.op);
            $display("token %s: got {%0d,%0d} want {%0d,%0d}", tag, g.val, g.op, e.val, e.op);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int nd;
        logic [9:0] dm;
        logic [7:0] om;

        tok.out_ready = 1'b1;

        // Reset state
        cyc(3);
        @(negedge clk);
        check("rst.valid",   int'(tok.out_valid),   0);
        check("rst.operand", int'(tok.out_operand), 0);
        check("rst.op",      int'(tok.out_op),      0);
        check_state("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // 1: 2,3 op1 -> {23,1}
        press("t1.d2", 10'd1 << 2, 8'd0, 6);
        press("t1.d3", 10'd1 << 3, 8'd0, 6);
        press("t1.op1", 10'd0, 8'd1 << 1, 6);
        check_tokens("t1");

        // 2: 4,5,6 op1; 2,3,4 op7
        press("t2.d4", 10'd1 << 4, 8'd0, 6);
        press("t2.d5", 10'd1 << 5, 8'd0, 6);
        press("t2.d6", 10'd1 << 6, 8'd0, 6);
        press("t2.op1", 10'd0, 8'd1 << 1, 6);
        press("t2.d2", 10'd1 << 2, 8'd0, 6);
        press("t2.d3", 10'd1 << 3, 8'd0, 6);
        press("t2.d4b", 10'd1 << 4, 8'd0, 6);
        press("t2.op7", 10'd0, 8'd1 << 7, 6);
        check_tokens("t2");

        // 3: digit overflow
        for (int k = 1; k <= 5; k++) press("t3.d", 10'd1 << k, 8'd0, 6);
        press("t3.op1", 10'd0, 8'd1 << 1, 6);
        check_tokens("t3");

        // 4: back-pressure
        tok.out_ready = 1'b0;
        press("t4.d7", 10'd1 << 7, 8'd0, 6);
        press("t4.op1", 10'd0, 8'd1 << 1, 6);
        check("t4.valid",   int'(tok.out_valid),   1);
        check("t4.operand", int'(tok.out_operand), 7);
        check("t4.op",      int'(tok.out_op),      1);
        press("t4.d9", 10'd1 << 9, 8'd0, 6);
        check("t4.valid2",   int'(tok.out_valid),   1);
        check("t4.operand2", int'(tok.out_operand), 7);
        @(posedge clk); #1;
        tok.out_ready = 1'b1;
        cyc(3);
        m_hold = 1'b0;
        @(negedge clk);
        check("t4.valid3", int'(tok.out_valid), 0);
        check_state("t4.end");
        check_tokens("t4");
        press("t4.d1", 10'd1 << 1, 8'd0, 6);   // proves IDLE: digit is taken

        // 5: glitch vs held press
        dbtn = 10'd1 << 5;
        cyc(3);
        dbtn = '0;
        cyc(10);
        check_state("t5.glitch");
        press("t5.held", 10'd1 << 5, 8'd0, 50);
        press("t5.op0", 10'd0, 8'd1, 6);
        check_tokens("t5");

        // 6: priority and reset mid-HOLD
        press("t6.d38", (10'd1 << 3) | (10'd1 << 8), 8'd0, 6);
        press("t6.d4op2", 10'd1 << 4, 8'd1 << 2, 6);
        check_tokens("t6");
        tok.out_ready = 1'b0;
        press("t6.op1", 10'd0, 8'd1 << 1, 6);
        check("t6.hold_valid", int'(tok.out_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6.rst_valid",   int'(tok.out_valid),   0);
        check("t6.rst_operand", int'(tok.out_operand), 0);
        check("t6.rst_op",      int'(tok.out_op),      0);
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
        exp_q.delete();
        got_q.delete();
        check_state("t6.rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tok.out_ready = 1'b1;
        cyc(2);

        // Randomised sequences, including multi-button patterns
        for (int r = 0; r < 20; r++) begin
            nd = int'($urandom_range(1, 6));
            for (int k = 0; k < nd; k++) begin
                dm = 10'($urandom_range(1, 1023));
                if ($urandom_range(0, 2) != 0) dm = 10'd1 << $urandom_range(0, 9);
                press("rnd.d", dm, 8'd0, int'($urandom_range(5, 12)));
            end
            om = 8'($urandom_range(1, 255));
            dm = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
            press("rnd.op", dm, om, int'($urandom_range(5, 12)));
            check_tokens("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
